// File: rtl/vmem_arb_ctrl.sv
// ============================================================================
// vmem_arb_ctrl
// ----------------------------------------------------------------------------
// Arbiter and sequencer for the single-port 24-bit video memory. Three
// requesters share the memory, served by fixed priority, one access per cycle:
//   1. display scan-out read   (disp_req)        - never stalled
//   2. host pixel-write FIFO   (wr_valid/ready)  - FIFO_DEPTH entries, in order
//   3. screen-fill engine      (fill_start)      - v-fastest raster of writes
//
// Optional feature macro: VMEM_FILL_EN
//   defined   : fill FSM, counters and colour latch are built.
//   undefined : fill_busy/fill_done tied low, fill_start/fill_color ignored,
//               arbitration is display over FIFO only.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   disp_req/addr      display read request and packed {h,v} address
//   disp_valid         mem_rdata carries display data for last cycle's request
//   wr_valid/ready     host write handshake; wr_addr {h,v}, wr_data RGB
//   fill_start/color   start a full-screen fill with the given RGB
//   fill_busy          fill in progress
//   fill_done          one-cycle pulse when the fill completes
//   mem_en/we          memory access strobe / write enable (from the grant)
//   mem_addr/wdata     memory address / write data
//   mem_rdata          memory read data (consumed downstream, not here)
// ============================================================================
module vmem_arb_ctrl #(
    parameter  int HSIZE      = 640,
    parameter  int VSIZE      = 480,
    parameter  int FIFO_DEPTH = 4,
    localparam int HW         = $clog2(HSIZE),
    localparam int VW         = $clog2(VSIZE),
    localparam int AW         = HW + VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          fill_start,
    input  logic [23:0]   fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [23:0]   mem_wdata,
    input  logic [23:0]   mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] H_MAX    = HW'(HSIZE - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(VSIZE - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [AW-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [23:0]   fifo_data_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    logic [AW-1:0] head_addr_s;
    logic [23:0]   head_data_s;
    logic [HW-1:0] head_h_s;
    logic [VW-1:0] head_v_s;
    logic          head_in_range_s;

    logic          disp_gnt_s;
    logic          fifo_gnt_s;
    logic          fill_gnt_s;
    logic          fill_req_s;
    logic [AW-1:0] fill_addr_s;
    logic [23:0]   fill_wdata_s;

    logic          disp_valid_r;

    // ------------------------------------------------------------------------
    // Host write FIFO
    // ------------------------------------------------------------------------
    assign full_s   = (count_r == CNT_FULL);
    assign empty_s  = (count_r == {(PW + 1){1'b0}});
    assign wr_ready = !full_s && !rst;
    assign push_s   = wr_valid && wr_ready;
    // Popping is tied to the grant, so an out-of-range head is consumed by the
    // same grant that suppresses its memory strobe.
    assign pop_s    = fifo_gnt_s;

    assign head_addr_s     = fifo_addr_r[rd_ptr_r];
    assign head_data_s     = fifo_data_r[rd_ptr_r];
    assign head_h_s        = head_addr_s[AW-1:VW];
    assign head_v_s        = head_addr_s[VW-1:0];
    assign head_in_range_s = (head_h_s <= H_MAX) && (head_v_s <= V_MAX);

    // FIFO storage: data only, validity is tracked by the pointers/count
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= wr_addr;
            fifo_data_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; reset discards any queued entries
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fill engine
    // ------------------------------------------------------------------------
`ifdef VMEM_FILL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    fill_state_e   state_r;
    logic [HW-1:0] fill_h_r;
    logic [VW-1:0] fill_v_r;
    logic [23:0]   fill_color_r;
    logic          fill_busy_r;
    logic          fill_done_r;
    logic          unused_s;

    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    assign fill_req_s   = fill_busy_r;
    assign fill_addr_s  = {fill_h_r, fill_v_r};
    assign fill_wdata_s = fill_color_r;
    assign fill_busy    = fill_busy_r;
    assign fill_done    = fill_done_r;
    assign unused_s     = ^mem_rdata;

    // Fill FSM: counters only advance on a fill grant, so stalls hold position
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fill_h_r     <= {HW{1'b0}};
            fill_v_r     <= {VW{1'b0}};
            fill_color_r <= 24'h000000;
            fill_busy_r  <= 1'b0;
            fill_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    fill_done_r <= 1'b0;
                    if (fill_start) begin
                        fill_color_r <= fill_color;
                        fill_h_r     <= {HW{1'b0}};
                        fill_v_r     <= {VW{1'b0}};
                        fill_busy_r  <= 1'b1;
                        state_r      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_gnt_s) begin
                        if (fill_v_r == V_MAX) begin
                            fill_v_r <= {VW{1'b0}};
                            if (fill_h_r == H_MAX) begin
                                // Last pixel {HSIZE-1,VSIZE-1} just written
                                fill_h_r    <= {HW{1'b0}};
                                fill_busy_r <= 1'b0;
                                fill_done_r <= 1'b1;
                                state_r     <= ST_DONE;
                            end else begin
                                fill_h_r <= fill_h_r + H_ONE;
                            end
                        end else begin
                            fill_v_r <= fill_v_r + V_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // fill_start is deliberately not looked at here
                    fill_done_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    fill_busy_r <= 1'b0;
                    fill_done_r <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_s;

    assign fill_req_s   = 1'b0;
    assign fill_addr_s  = {AW{1'b0}};
    assign fill_wdata_s = 24'h000000;
    assign fill_busy    = 1'b0;
    assign fill_done    = 1'b0;
    assign unused_s     = ^{fill_start, fill_color, mem_rdata};
`endif

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Fixed priority grant: display, then FIFO head, then fill
    always_comb begin
        disp_gnt_s = 1'b0;
        fifo_gnt_s = 1'b0;
        fill_gnt_s = 1'b0;
        if (disp_req) begin
            disp_gnt_s = 1'b1;
        end else if (!empty_s) begin
            fifo_gnt_s = 1'b1;
        end else if (fill_req_s) begin
            fill_gnt_s = 1'b1;
        end else begin
            disp_gnt_s = 1'b0;
        end
    end

    // Memory port mux driven straight from the grant
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = 24'h000000;
        if (disp_gnt_s) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (fifo_gnt_s) begin
            // An out-of-range entry still pops, but produces no access
            mem_en    = head_in_range_s;
            mem_we    = head_in_range_s;
            mem_addr  = head_addr_s;
            mem_wdata = head_data_s;
        end else if (fill_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fill_addr_s;
            mem_wdata = fill_wdata_s;
        end else begin
            mem_en = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Display read return
    // ------------------------------------------------------------------------
    // Display reads always win, so read data returns exactly one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid_r <= 1'b0;
        end else begin
            disp_valid_r <= disp_req;
        end
    end

    assign disp_valid = disp_valid_r;

endmodule

// File: doc/vmem_arb_ctrl.md
# vmem_arb_ctrl

Arbiter and sequencer for the single-port 24-bit video memory behind the VGA controller. It shares the memory between three requesters: the display scan-out read, a buffered host pixel-write port, and a built-in screen-fill engine. Every cycle it issues at most one memory access, chosen by fixed priority. It sits between `vga_ctrl`'s address outputs, the host/CPU pixel writer, and the video RAM.

## Interface
Parameters:
- `HSIZE`, 640, horizontal pixels; `HW = $clog2(HSIZE)`
- `VSIZE`, 480, vertical lines; `VW = $clog2(VSIZE)`
- `FIFO_DEPTH`, 4, host write FIFO entries (power of 2, ≥2)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `disp_req`  in  1  display read request this cycle
- `disp_addr`  in  HW+VW  display address, packed `{h,v}`
- `disp_valid`  out  1  `mem_rdata` holds display data for the previous cycle's request
- `wr_valid` / `wr_ready`  in / out  1  host write handshake
- `wr_addr`  in  HW+VW  host pixel address `{h,v}`
- `wr_data`  in  24  host pixel RGB
- `fill_start`  in  1  start a full-screen fill
- `fill_color`  in  24  fill RGB, sampled with `fill_start`
- `fill_busy`  out  1  fill in progress
- `fill_done`  out  1  one-cycle pulse when the fill completes
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable
- `mem_addr`  out  HW+VW  memory address
- `mem_wdata`  out  24  memory write data
- `mem_rdata`  in  24  memory read data, valid one cycle after a read

## Operation
- Grant priority each cycle:
  - display read if `disp_req`;
  - else FIFO head, if the FIFO is non-empty;
  - else fill write, if `fill_busy`.
  - `mem_*` are combinational from the grant. `mem_en=0` when there is no requester.
- Display grant: `mem_we=0`, `mem_addr=disp_addr`. Display reads are never stalled.
- Host FIFO:
  - `wr_ready = !full && !rst`.
  - Push on `wr_valid && wr_ready`.
  - Pop only on a FIFO grant. No bypass, so an entry pushed in cycle N is issued no earlier than N+1.
  - The FIFO can push and pop in the same cycle when it is neither full nor empty.
  - Entries issue in acceptance order.
- Out-of-range host write (`h ≥ HSIZE` or `v ≥ VSIZE`): popped on grant with `mem_en=0`, so no memory write. The slot is consumed.
- Fill FSM states:
  - IDLE: on `fill_start`, latch `fill_color`, clear the `h` and `v` counters, go to FILL. `fill_busy=1` from the next cycle.
  - FILL: on each fill grant, write `{h,v}`, then advance the counters. `v` increments; at `VSIZE-1`, `v` goes to 0 and `h` increments. After granting `{HSIZE-1,VSIZE-1}`, go to DONE.
  - DONE: `fill_done=1` and `fill_busy=0` for one cycle, then IDLE.
- `fill_start` while in FILL or DONE is ignored.
- Fill writes only in-range addresses: exactly HSIZE×VSIZE writes per fill.

## Timing
- Reset values:
  - `disp_valid=0`, `fill_busy=0`, `fill_done=0`;
  - FIFO empty, `wr_ready=0` while `rst` is high, 1 the cycle after;
  - `mem_en=0` unless `disp_req`.
- Reset mid-fill aborts the fill with no `fill_done`. FIFO contents are discarded.
- `disp_valid` is `disp_req` registered: one-cycle latency, with data taken from `mem_rdata` in that cycle.
- Fill with an idle bus: `fill_start` at cycle 0 gives `fill_busy` at cycle 1. Writes run in cycles 1 … HSIZE·VSIZE, and `fill_done` asserts in cycle HSIZE·VSIZE+1.
- Stalled fill or FIFO requests hold their state. Nothing is dropped except out-of-range host writes.

## Configuration
- `VMEM_FILL_EN` defined: fill engine present as described.
- `VMEM_FILL_EN` undefined:
  - fill FSM and counters are removed;
  - `fill_busy` and `fill_done` are tied to 0;
  - `fill_start` and `fill_color` are ignored;
  - arbitration is display over FIFO only.

## Test plan
- Reset and display reads: after reset, drive `disp_req=1` with `disp_addr={10'd3,9'd5}`. Require `mem_en=1`, `mem_we=0`, `mem_addr` equal to that address, and `disp_valid=1` the next cycle.
- FIFO full: with `disp_req=1` held, push 4 writes. Require `wr_ready=0` after the 4th and no `mem_we`. Release `disp_req`. Require the 4 writes issued in order on consecutive cycles, then `wr_ready=1`.
- Out-of-range drop: push `wr_addr={10'd640,9'd0}` followed by `{10'd1,9'd1}`. Require exactly one memory write, to `{1,1}`.
- Small fill: with `HSIZE=4`, `VSIZE=3`, pulse `fill_start` with `fill_color=24'hFF0000`. Require 12 writes in v-fastest order from `{0,0}` to `{3,2}`, `fill_done` in cycle 13, and a second `fill_start` during FILL ignored.
- Contention: during a fill, interleave `disp_req` pulses and host writes. Require display granted first, host second, fill resumed at the correct counter, and the final write count still 12.
- Mid-fill reset: assert `rst` at write 5. Require `fill_busy=0`, no `fill_done`, and the FIFO empty. With `VMEM_FILL_EN` undefined, `fill_start` must produce no writes.
